// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC sequencer feeding a small {pc, instr} fetch FIFO with redirect, halt and fault handling.
// Optional macro IF_FETCH_PERF_EN adds fetch/stall/flush performance counters.
module if_fetch_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h0,
  parameter int          IMEM_WORDS = 32,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [1:0]  state_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;
  localparam logic [1:0] RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0] bpc_q [BUF_DEPTH];
  logic [31:0] bpc_d [BUF_DEPTH];
  logic [31:0] bins_q [BUF_DEPTH];
  logic [31:0] bins_d [BUF_DEPTH];
  logic empty, full, pop, can_fetch, oor, push, redir, bad_tgt;
  assign imem_addr = pc_q;
  assign empty     = wr_q == rd_q;
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop       = !empty && out_ready;
  assign redir     = redirect_valid && state_q != FAULT;
  assign bad_tgt   = redir && redirect_target[1:0] != 2'b00;
  assign can_fetch = state_q == RUN && !halt_req && !redirect_valid && (!full || pop);
  assign oor       = {1'b0, pc_q} >= IMEM_BYTES;
  assign push      = can_fetch && !oor;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
    bpc_q  <= bpc_d;
    bins_q <= bins_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q != FAULT)
      state_d = (bad_tgt || (can_fetch && oor)) ? FAULT : halt_req ? HALTED : RUN;
  end
  // A redirect flushes the FIFO outright; a pop in that cycle has already consumed the old head.
  always_comb begin
    pc_d   = pc_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    bpc_d  = bpc_q;
    bins_d = bins_q;
    if (redir) begin
      pc_d = redirect_target;
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) begin
        bpc_d[wr_q[AW-1:0]]  = pc_q;
        bins_d[wr_q[AW-1:0]] = imem_instr;
        wr_d                 = wr_q + 1'b1;
        pc_d                 = pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + 1'b1;
    end
  end
  always_comb begin
    out_valid    = !empty;
    out_pc       = out_valid ? bpc_q[rd_q[AW-1:0]] : 32'h0;
    out_instr    = out_valid ? bins_q[rd_q[AW-1:0]] : 32'h0;
    out_pc_plus4 = out_valid ? out_pc + 32'd4 : 32'h0;
    fault        = state_q == FAULT;
    state_o      = state_q;
  end
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(push);
      stall_cnt_q <= stall_cnt_q + 32'(state_q == RUN && !halt_req && !redirect_valid && full && !pop);
      flush_cnt_q <= flush_cnt_q + 32'(redir);
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule
